cabac_bin_sequencer: RTL and testbench

Control block that sequences the VVC arithmetic-decoding engine (the DecodeBinEP/regular/terminate datapath and its range/value/bitsNeeded registers) for one slice. It runs engine initialisation from the first bitstream bytes, and accepts bin requests from the syntax parser, including multi-bin bypass bursts. It issues one engine operation at a time and services engine byte-refill requests through a request/acknowledge byte source. It sits between the syntax parser, the bin engine and the byte reader, and is the only block that drives the engine's go, init and byte-load strobes.

---
 rtl/cabac_bin_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_cabac_bin_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_bin_sequencer.sv
// cabac_bin_sequencer: sequences the CABAC arithmetic-decoding engine for one
// slice. It fetches the init bytes and services parser bin requests, including
// bypass bursts, one engine operation at a time, with byte refills when the
// engine runs dry.
module cabac_bin_sequencer #(
    parameter int INIT_BYTES = 2,
    parameter int MAX_BURST  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_mode,
    input  logic [5:0]           req_count,
    output logic                 rsp_valid,
    output logic [MAX_BURST-1:0] rsp_word,
    output logic                 slice_end,
    output logic                 err,
    output logic                 eng_init,
    output logic [31:0]          init_value,
    output logic                 eng_go,
    output logic [1:0]           eng_mode,
    input  logic                 eng_done,
    input  logic                 eng_bin,
    input  logic                 eng_need_byte,
    output logic                 eng_byte_load,
    output logic [7:0]           eng_byte,
    output logic                 byte_req,
    input  logic                 byte_ack,
    input  logic [7:0]           byte_data,
    input  logic                 byte_eof,
    output logic [15:0]          bin_count
);

    localparam logic [2:0] LAST_INIT = 3'(INIT_BYTES - 1);
    localparam logic [1:0] MODE_BYP  = 2'd1;
    localparam logic [1:0] MODE_TERM = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_FETCH, S_INIT_LOAD, S_READY, S_ISSUE,
        S_WAIT, S_REFILL, S_RESPOND, S_END
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          init_value_q, init_value_d;
    logic [2:0]           init_cnt_q, init_cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic [5:0]           remaining_q, remaining_d;
    logic [MAX_BURST-1:0] rsp_word_q, rsp_word_d;
    logic [15:0]          bin_count_q, bin_count_d;
    logic                 slice_end_q, slice_end_d;
    logic                 err_q, err_d;
    logic                 bad_rsp_q, bad_rsp_d;

    logic                 req_illegal;
    logic                 more_bins;
    logic                 start_ok;
    logic [7:0]           fetched_byte;

    // Request legality, burst continuation and underflow byte substitution.
    always_comb begin
        req_illegal  = (req_mode == 2'd3) ||
                       ((req_mode == MODE_BYP) &&
                        ((req_count == 6'd0) || ({26'd0, req_count} > 32'(MAX_BURST))));
        more_bins    = (mode_q == MODE_BYP) && (remaining_q > 6'd1);
        start_ok     = start && ((state_q == S_IDLE) || (state_q == S_READY) || (state_q == S_END));
        fetched_byte = byte_eof ? 8'h00 : byte_data;
    end

    // Next-state and register-update logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        init_value_d = init_value_q;
        init_cnt_d   = init_cnt_q;
        mode_d       = mode_q;
        remaining_d  = remaining_q;
        rsp_word_d   = rsp_word_q;
        bin_count_d  = bin_count_q;
        slice_end_d  = slice_end_q;
        err_d        = err_q;
        bad_rsp_d    = 1'b0;

        if (start_ok) begin
            state_d      = S_INIT_FETCH;
            init_value_d = 32'd0;
            init_cnt_d   = 3'd0;
            bin_count_d  = 16'd0;
            slice_end_d  = 1'b0;
            err_d        = 1'b0;
        end else begin
            case (state_q)
                S_INIT_FETCH: begin
                    if (byte_ack) begin
                        init_value_d = {init_value_q[23:0], fetched_byte};
                        init_cnt_d   = init_cnt_q + 3'd1;
                        if (byte_eof) err_d = 1'b1;
                        if (init_cnt_q == LAST_INIT) state_d = S_INIT_LOAD;
                    end
                end
                S_INIT_LOAD: state_d = S_READY;
                S_READY: begin
                    if (req_valid) begin
                        rsp_word_d = '0;
                        if (req_illegal) begin
                            err_d     = 1'b1;
                            bad_rsp_d = 1'b1;
                        end else begin
                            mode_d      = req_mode;
                            remaining_d = (req_mode == MODE_BYP) ? req_count : 6'd1;
                            state_d     = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: state_d = S_WAIT;
                S_WAIT: begin
                    if (eng_done) begin
                        rsp_word_d  = {rsp_word_q[MAX_BURST-2:0], eng_bin};
                        bin_count_d = (bin_count_q == 16'hFFFF) ? bin_count_q : bin_count_q + 16'd1;
                        if (eng_need_byte) begin
                            state_d = S_REFILL;
                        end else if (more_bins) begin
                            remaining_d = remaining_q - 6'd1;
                            state_d     = S_ISSUE;
                        end else begin
                            state_d = S_RESPOND;
                        end
                    end
                end
                S_REFILL: begin
                    if (byte_ack) begin
                        if (byte_eof) err_d = 1'b1;
                        if (more_bins) begin
                            remaining_d = remaining_q - 6'd1;
                            state_d     = S_ISSUE;
                        end else begin
                            state_d = S_RESPOND;
                        end
                    end
                end
                S_RESPOND: begin
                    if ((mode_q == MODE_TERM) && rsp_word_q[0]) begin
                        slice_end_d = 1'b1;
                        state_d     = S_END;
                    end else begin
                        state_d = S_READY;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State and datapath registers; reset returns everything to zero/IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            init_value_q <= 32'd0;
            init_cnt_q   <= 3'd0;
            mode_q       <= 2'd0;
            remaining_q  <= 6'd0;
            rsp_word_q   <= '0;
            bin_count_q  <= 16'd0;
            slice_end_q  <= 1'b0;
            err_q        <= 1'b0;
            bad_rsp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_value_q <= init_value_d;
            init_cnt_q   <= init_cnt_d;
            mode_q       <= mode_d;
            remaining_q  <= remaining_d;
            rsp_word_q   <= rsp_word_d;
            bin_count_q  <= bin_count_d;
            slice_end_q  <= slice_end_d;
            err_q        <= err_d;
            bad_rsp_q    <= bad_rsp_d;
        end
    end

    assign req_ready     = (state_q == S_READY);
    assign rsp_valid     = (state_q == S_RESPOND) || bad_rsp_q;
    assign rsp_word      = rsp_word_q;
    assign slice_end     = slice_end_q;
    assign err           = err_q;
    assign eng_init      = (state_q == S_INIT_LOAD);
    assign init_value    = init_value_q;
    assign eng_go        = (state_q == S_ISSUE);
    assign eng_mode      = mode_q;
    assign byte_req      = (state_q == S_INIT_FETCH) || (state_q == S_REFILL);
    assign eng_byte_load = (state_q == S_REFILL) && byte_ack;
    assign eng_byte      = eng_byte_load ? fetched_byte : 8'h00;
    assign bin_count     = bin_count_q;

endmodule

// File: tb/tb_cabac_bin_sequencer.sv
// tb_cabac_bin_sequencer: directed stimulus with a response scoreboard, plus
// small behavioural models of the bin engine and the byte reader.
module tb_cabac_bin_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, req_valid;
    logic        req_ready, rsp_valid, slice_end, err;
    logic [1:0]  req_mode, eng_mode;
    logic [5:0]  req_count;
    logic [31:0] rsp_word, init_value;
    logic        eng_init, eng_go, eng_done, eng_bin, eng_need_byte, eng_byte_load;
    logic [7:0]  eng_byte, byte_data;
    logic        byte_req, byte_ack, byte_eof;
    logic [15:0] bin_count;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          go_count = 0;
    int          go_at_load = 0;
    int          init_cycle = 0;
    int          rsp_cycle = 0;
    int          hs_cycle = 0;
    int          start_cycle = 0;
    int          ready_cycle = 0;
    int          waited = 0;
    logic [31:0] init_seen = 32'd0;
    bit          go_seen = 1'b0;
    bit          eng_hold = 1'b0;

    logic [31:0] exp_rsp[$];
    logic [7:0]  exp_load[$];
    bit          eng_bins[$];
    bit          eng_needs[$];
    logic [7:0]  rd_data[$];
    bit          rd_eof[$];
    int          rd_delay[$];

    cabac_bin_sequencer #(.INIT_BYTES(2), .MAX_BURST(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode), .req_count(req_count),
        .rsp_valid(rsp_valid), .rsp_word(rsp_word), .slice_end(slice_end), .err(err),
        .eng_init(eng_init), .init_value(init_value), .eng_go(eng_go), .eng_mode(eng_mode),
        .eng_done(eng_done), .eng_bin(eng_bin), .eng_need_byte(eng_need_byte),
        .eng_byte_load(eng_byte_load), .eng_byte(eng_byte),
        .byte_req(byte_req), .byte_ack(byte_ack), .byte_data(byte_data), .byte_eof(byte_eof),
        .bin_count(bin_count)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportMissing(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: got event expected none (nothing queued)", name);
    endtask

    // Monitor: scoreboard pops on responses and byte loads, tracks engine strobes.
    always @(negedge clk) begin
        if (!reset) begin
            if (rsp_valid) begin
                rsp_cycle = cyc;
                if (exp_rsp.size() == 0) reportMissing("unexpected_rsp");
                else checkOutput("rsp_word", rsp_word, exp_rsp.pop_front());
            end
            if (eng_byte_load) begin
                go_at_load = go_count;
                if (exp_load.size() == 0) reportMissing("unexpected_byte_load");
                else checkOutput("eng_byte", {24'd0, eng_byte}, {24'd0, exp_load.pop_front()});
            end
            if (eng_go) begin
                go_count++;
                go_seen = 1'b1;
                checkOutput("go_during_refill", {31'd0, byte_req}, 32'd0);
            end
            if (eng_init) begin
                init_cycle = cyc;
                init_seen  = init_value;
            end
        end
    end

    // Engine model: completes each operation one cycle after eng_go.
    initial begin
        eng_done = 1'b0; eng_bin = 1'b0; eng_need_byte = 1'b0;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0; eng_bin = 1'b0; eng_need_byte = 1'b0;
            if (go_seen && !eng_hold && !reset) begin
                go_seen = 1'b0;
                if (eng_bins.size() == 0) begin
                    reportMissing("unexpected_eng_go");
                end else begin
                    eng_done      = 1'b1;
                    eng_bin       = eng_bins.pop_front();
                    eng_need_byte = eng_needs.pop_front();
                end
            end
        end
    end

    // Byte reader model: acks after the queued number of request cycles.
    initial begin
        byte_ack = 1'b0; byte_data = 8'h00; byte_eof = 1'b0;
        forever begin
            @(posedge clk); #1;
            byte_ack = 1'b0; byte_data = 8'h00; byte_eof = 1'b0;
            if (byte_req && !reset && rd_data.size() != 0) begin
                if (waited >= rd_delay[0]) begin
                    byte_ack  = 1'b1;
                    byte_data = rd_data.pop_front();
                    byte_eof  = rd_eof.pop_front();
                    void'(rd_delay.pop_front());
                    waited = 0;
                end else begin
                    waited++;
                end
            end
        end
    end

    task automatic pushByte(input logic [7:0] d, input bit eof, input int dly);
        rd_data.push_back(d);
        rd_eof.push_back(eof);
        rd_delay.push_back(dly);
    endtask

    task automatic pushBin(input bit b, input bit need);
        eng_bins.push_back(b);
        eng_needs.push_back(need);
    endtask

    task automatic waitReady();
        int n = 0;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        ready_cycle = cyc;
        checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic doStart(input logic [7:0] b0, input logic [7:0] b1, input int dly);
        pushByte(b0, 1'b0, dly);
        pushByte(b1, 1'b0, dly);
        start = 1'b1;
        start_cycle = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        waitReady();
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [5:0] count);
        int n = 0;
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL req_ready_timeout: got 0 expected 1");
        end else begin
            req_valid = 1'b1;
            req_mode  = mode;
            req_count = count;
            hs_cycle  = cyc;
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_rsp.size() != 0 || exp_load.size() != 0) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checkOutput("queues_drained", exp_rsp.size() + exp_load.size(), 32'd0);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_ctl"},
                    {14'd0, req_ready, rsp_valid, slice_end, err, eng_init, eng_go,
                     eng_byte_load, byte_req, eng_mode, eng_byte}, 32'd0);
        checkOutput({name, "_init_value"}, init_value, 32'd0);
        checkOutput({name, "_rsp_word"}, rsp_word, 32'd0);
        checkOutput({name, "_bin_count"}, {16'd0, bin_count}, 32'd0);
    endtask

    // Watchdog: stops a run that has stalled beyond every bounded wait.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int g;
        int n;
        reset = 1'b1; start = 1'b0; req_valid = 1'b0; req_mode = 2'd0; req_count = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        checkIdle("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        $display("[TB] init fetch 0x8C 0xD1");
        doStart(8'h8C, 8'hD1, 0);
        checkOutput("init_latency", init_cycle - start_cycle, 32'd3);
        checkOutput("init_value", init_seen, 32'h0000_8CD1);
        checkOutput("ready_latency", ready_cycle - start_cycle, 32'd4);

        $display("[TB] single regular bin");
        pushBin(1'b1, 1'b0);
        exp_rsp.push_back(32'h1);
        applyStimulus(2'd0, 6'd1);
        waitDrain();
        checkOutput("single_rsp_latency", rsp_cycle - hs_cycle, 32'd3);
        checkOutput("bin_count_1", {16'd0, bin_count}, 32'd1);

        $display("[TB] bypass burst of 5");
        g = go_count;
        pushBin(1'b1, 1'b0); pushBin(1'b0, 1'b0); pushBin(1'b1, 1'b0);
        pushBin(1'b1, 1'b0); pushBin(1'b0, 1'b0);
        exp_rsp.push_back(32'h16);
        applyStimulus(2'd1, 6'd5);
        waitDrain();
        checkOutput("burst_go_count", go_count - g, 32'd5);
        checkOutput("bin_count_6", {16'd0, bin_count}, 32'd6);

        $display("[TB] refill mid-burst");
        g = go_count;
        pushBin(1'b1, 1'b0); pushBin(1'b1, 1'b1); pushBin(1'b0, 1'b0);
        pushByte(8'hA5, 1'b0, 3);
        exp_load.push_back(8'hA5);
        exp_rsp.push_back(32'h6);
        applyStimulus(2'd1, 6'd3);
        waitDrain();
        checkOutput("refill_go_count", go_count - g, 32'd3);
        checkOutput("refill_before_3rd_go", go_at_load - g, 32'd2);
        checkOutput("bin_count_9", {16'd0, bin_count}, 32'd9);

        $display("[TB] terminate bin 1");
        pushBin(1'b1, 1'b0);
        exp_rsp.push_back(32'h1);
        applyStimulus(2'd2, 6'd1);
        waitDrain();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("slice_end_set", {31'd0, slice_end}, 32'd1);
        checkOutput("end_not_ready", {31'd0, req_ready}, 32'd0);
        checkOutput("bin_count_10", {16'd0, bin_count}, 32'd10);
        checkOutput("err_clear", {31'd0, err}, 32'd0);

        $display("[TB] restart after slice end");
        doStart(8'h12, 8'h34, 1);
        checkOutput("slice_end_cleared", {31'd0, slice_end}, 32'd0);
        checkOutput("bin_count_cleared", {16'd0, bin_count}, 32'd0);
        checkOutput("init_value_2", init_seen, 32'h0000_1234);

        $display("[TB] illegal mode 3");
        exp_rsp.push_back(32'h0);
        applyStimulus(2'd3, 6'd1);
        waitDrain();
        checkOutput("err_mode3", {31'd0, err}, 32'd1);
        checkOutput("ready_after_illegal", {31'd0, req_ready}, 32'd1);

        $display("[TB] restart from READY, then bypass count 0 and 33");
        doStart(8'h00, 8'h01, 0);
        checkOutput("err_cleared", {31'd0, err}, 32'd0);
        exp_rsp.push_back(32'h0);
        applyStimulus(2'd1, 6'd0);
        waitDrain();
        checkOutput("err_count0", {31'd0, err}, 32'd1);
        exp_rsp.push_back(32'h0);
        applyStimulus(2'd1, 6'd33);
        waitDrain();
        checkOutput("bin_count_illegal", {16'd0, bin_count}, 32'd0);

        $display("[TB] underflow during refill");
        doStart(8'hFF, 8'hEE, 0);
        checkOutput("err_cleared_2", {31'd0, err}, 32'd0);
        pushBin(1'b0, 1'b1); pushBin(1'b1, 1'b0);
        pushByte(8'hFF, 1'b1, 0);
        exp_load.push_back(8'h00);
        exp_rsp.push_back(32'h1);
        applyStimulus(2'd1, 6'd2);
        waitDrain();
        checkOutput("err_underflow", {31'd0, err}, 32'd1);
        pushBin(1'b1, 1'b0);
        exp_rsp.push_back(32'h1);
        applyStimulus(2'd0, 6'd1);
        waitDrain();
        checkOutput("err_sticky", {31'd0, err}, 32'd1);
        checkOutput("bin_count_3", {16'd0, bin_count}, 32'd3);

        $display("[TB] terminate bin 0");
        pushBin(1'b0, 1'b0);
        exp_rsp.push_back(32'h0);
        applyStimulus(2'd2, 6'd1);
        waitDrain();
        checkOutput("term0_no_slice_end", {31'd0, slice_end}, 32'd0);
        checkOutput("term0_ready", {31'd0, req_ready}, 32'd1);

        $display("[TB] reset during WAIT");
        eng_hold = 1'b1;
        g = go_count;
        applyStimulus(2'd0, 6'd1);
        n = 0;
        while (go_count == g && n < 20) begin @(posedge clk); #1; n++; end
        checkOutput("reset_test_go", go_count - g, 32'd1);
        reset = 1'b1;
        #1;
        checkIdle("async_reset");
        @(posedge clk); #1;
        checkIdle("reset_edge");
        go_seen  = 1'b0;
        eng_hold = 1'b0;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkIdle("idle_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
